// File: rtl/mspu_dbg_pkg.sv
// Shared debug-path types: dump FSM state encoding and register-file geometry.
package mspu_dbg_pkg;

    typedef enum logic [1:0] {
        DUMP_IDLE,
        DUMP_LOAD,
        DUMP_SEND,
        DUMP_DONE
    } dump_state_t;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready word stream from the register-file dumper to the debug link.
interface regfile_dump_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              dout_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout_data;
    logic [ADDR_W-1:0] dout_idx;
    logic              dout_last;

    modport master (
        output dout_valid,
        input  dout_ready,
        output dout_data,
        output dout_idx,
        output dout_last
    );

    modport slave (
        input  dout_valid,
        output dout_ready,
        input  dout_data,
        input  dout_idx,
        input  dout_last
    );
endinterface

// File: rtl/regfile_dump.sv
// Walks register indices FIRST_REG..NUM_REGS-1 through read port A while the core is
// halted and streams each value out; index 0 always reads as zero.
module regfile_dump
    import mspu_dbg_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int DATA_W    = REG_DATA_W,
    parameter int FIRST_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    regfile_dump_if.master    dout
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);

    dump_state_t       r_state;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_done;
    logic              r_aborted;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_idx;
    logic              r_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= DUMP_IDLE;
            r_raddr   <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_idx     <= '0;
            r_last    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                DUMP_IDLE: begin
                    if (start && !run) begin
                        r_raddr <= FIRST_IDX;
                        r_state <= DUMP_LOAD;
                    end
                end
                DUMP_LOAD: begin
                    if (run) begin
                        r_valid   <= 1'b0;
                        r_aborted <= 1'b1;
                        r_state   <= DUMP_IDLE;
                    end else begin
                        r_data  <= (r_raddr == '0) ? '0 : rdata;
                        r_idx   <= r_raddr;
                        r_last  <= (r_raddr == LAST_IDX);
                        r_valid <= 1'b1;
                        r_state <= DUMP_SEND;
                    end
                end
                DUMP_SEND: begin
                    // run wins over a handshake landing on the same edge
                    if (run) begin
                        r_valid   <= 1'b0;
                        r_aborted <= 1'b1;
                        r_state   <= DUMP_IDLE;
                    end else if (dout.dout_ready) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= DUMP_DONE;
                        end else begin
                            r_raddr <= r_raddr + ADDR_W'(1);
                            r_state <= DUMP_LOAD;
                        end
                    end
                end
                DUMP_DONE: begin
                    r_state <= DUMP_IDLE;
                end
                default: begin
                    r_state <= DUMP_IDLE;
                end
            endcase
        end
    end

    assign busy            = (r_state != DUMP_IDLE);
    assign done            = r_done;
    assign aborted         = r_aborted;
    assign raddr           = r_raddr;
    assign dout.dout_valid = r_valid;
    assign dout.dout_data  = r_data;
    assign dout.dout_idx   = r_idx;
    assign dout.dout_last  = r_last;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: stimulus pushes expected words, negedge monitors pop and compare.
module tb_regfile_dump;

    typedef struct packed {
        logic        last;
        logic [4:0]  idx;
        logic [31:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        start;
    logic        busy, done, aborted;
    logic [4:0]  raddr;
    logic [31:0] rdata;

    logic        run_b;
    logic        start_b;
    logic        busy_b, done_b, aborted_b;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_b;

    logic [31:0] regs [32];

    int total = 0;
    int bad   = 0;
    int words_a = 0, words_b = 0;
    int done_cnt = 0, abort_cnt = 0;

    word_t q_a[$];
    word_t q_b[$];

    logic  hold_pending = 1'b0;
    word_t hold_word;

    always #5 clk = ~clk;

    regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) dif_a ();
    regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) dif_b ();

    assign rdata   = regs[raddr];
    assign rdata_b = regs[raddr_b];

    regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(0)) dut_a (
        .clk(clk), .reset(rst_n), .run(run), .start(start),
        .busy(busy), .done(done), .aborted(aborted),
        .raddr(raddr), .rdata(rdata), .dout(dif_a)
    );

    regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(30)) dut_b (
        .clk(clk), .reset(rst_n), .run(run_b), .start(start_b),
        .busy(busy_b), .done(done_b), .aborted(aborted_b),
        .raddr(raddr_b), .rdata(rdata_b), .dout(dif_b)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic word_t mk_word(input int i);
        word_t w;
        w.idx  = 5'(i);
        w.data = (i == 0) ? 32'h0 : 32'hA500_0000 + 32'(i);
        w.last = (i == 31);
        return w;
    endfunction

    task automatic push_a(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) q_a.push_back(mk_word(i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor A: handshakes, hold stability while stalled, done/aborted pulses
    always @(negedge clk) begin
        word_t cur, e;
        cur = {dif_a.dout_last, dif_a.dout_idx, dif_a.dout_data};
        if (hold_pending)
            chk("a_hold_stable", {31'd0, dif_a.dout_valid, cur}, {31'd0, 1'b1, hold_word});
        hold_pending = rst_n && !run && dif_a.dout_valid && !dif_a.dout_ready;
        hold_word    = cur;
        if (rst_n && !run && dif_a.dout_valid && dif_a.dout_ready) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_word", {27'd0, cur}, 64'h0);
            end else begin
                e = q_a.pop_front();
                chk("a_word", {27'd0, cur}, {27'd0, e});
                words_a++;
            end
        end
        if (done)    done_cnt++;
        if (aborted) abort_cnt++;
        if (done || aborted) chk("a_done_abort_excl", {63'd0, done && aborted}, 64'd0);
    end

    always @(negedge clk) begin
        word_t cur, e;
        cur = {dif_b.dout_last, dif_b.dout_idx, dif_b.dout_data};
        if (rst_n && dif_b.dout_valid && dif_b.dout_ready) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_word", {27'd0, cur}, 64'h0);
            end else begin
                e = q_b.pop_front();
                chk("b_word", {27'd0, cur}, {27'd0, e});
                words_b++;
            end
        end
    end

    initial begin
        int n;
        int d0, w0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 + 32'(i);
        rst_n = 1'b0; run = 1'b0; start = 1'b0;
        run_b = 1'b0; start_b = 1'b0;
        dif_a.dout_ready = 1'b1;
        dif_b.dout_ready = 1'b1;
        tick(); tick();
        chk("rst_busy",    {63'd0, busy},             64'd0);
        chk("rst_valid",   {63'd0, dif_a.dout_valid}, 64'd0);
        chk("rst_raddr",   {59'd0, raddr},            64'd0);
        chk("rst_done",    {62'd0, done, aborted},    64'd0);
        chk("rst_b_busy",  {63'd0, busy_b},           64'd0);
        rst_n = 1'b1;
        tick();

        // 1: full dump at ready=1, latency and total length
        push_a(0, 31);
        d0 = done_cnt; w0 = words_a;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy_load",  {63'd0, busy},             64'd1);
        chk("t1_valid_load", {63'd0, dif_a.dout_valid}, 64'd0);
        tick();
        chk("t1_valid_lat",  {63'd0, dif_a.dout_valid}, 64'd1);
        chk("t1_first_idx",  {59'd0, dif_a.dout_idx},   64'd0);
        n = 2;
        while (!done && n < 200) begin tick(); n++; end
        chk("t1_done_seen", {63'd0, done}, 64'd1);
        chk("t1_cycles", 64'(n), 64'd65);
        tick();
        chk("t1_done_pulse", {63'd0, done}, 64'd0);
        chk("t1_idle",       {63'd0, busy}, 64'd0);
        chk("t1_words", 64'(words_a - w0), 64'd32);
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

        // 2: random backpressure
        push_a(0, 31);
        w0 = words_a;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 2000) begin
            dif_a.dout_ready = 1'($urandom_range(0, 1));
            tick(); n++;
        end
        dif_a.dout_ready = 1'b1;
        chk("t2_done_seen", {63'd0, done}, 64'd1);
        chk("t2_words", 64'(words_a - w0), 64'd32);
        tick();

        // 3: run asserted during SEND of idx 7, with ready high
        push_a(0, 6);
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(dif_a.dout_valid && dif_a.dout_idx == 5'd7) && n < 100) begin tick(); n++; end
        chk("t3_reach_idx7", {63'd0, dif_a.dout_valid}, 64'd1);
        run = 1'b1;
        tick();
        chk("t3_valid_drop", {63'd0, dif_a.dout_valid}, 64'd0);
        chk("t3_aborted",    {63'd0, aborted},          64'd1);
        chk("t3_busy",       {63'd0, busy},             64'd0);
        tick();
        chk("t3_abort_pulse", {63'd0, aborted}, 64'd0);
        chk("t3_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t3_queue_empty", 64'(q_a.size()), 64'd0);

        // 4: start while running is ignored; restarts during a dump are ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_run_start_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("t4_run_start_busy2", {63'd0, busy}, 64'd0);
        run = 1'b0;
        push_a(0, 31);
        w0 = words_a; d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            start = (n == 10 || n == 41);
            tick(); n++;
        end
        start = 1'b0;
        chk("t4_done_seen", {63'd0, done}, 64'd1);
        chk("t4_words", 64'(words_a - w0), 64'd32);
        tick(); tick();
        chk("t4_no_restart", {63'd0, busy}, 64'd0);
        chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);

        // 5: reset mid-dump at idx 12, then a fresh dump from idx 0
        push_a(0, 11);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(dif_a.dout_valid && dif_a.dout_idx == 5'd12) && n < 100) begin tick(); n++; end
        chk("t5_reach_idx12", {63'd0, dif_a.dout_valid}, 64'd1);
        rst_n = 1'b0;
        dif_a.dout_ready = 1'b0;
        tick();
        chk("t5_rst_outs", {22'd0, busy, done, aborted, raddr, dif_a.dout_valid,
                            dif_a.dout_data, dif_a.dout_idx, dif_a.dout_last}, 64'd0);
        chk("t5_queue_empty", 64'(q_a.size()), 64'd0);
        rst_n = 1'b1;
        dif_a.dout_ready = 1'b1;
        tick();
        push_a(0, 31);
        w0 = words_a;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin tick(); n++; end
        chk("t5_done_seen", {63'd0, done}, 64'd1);
        chk("t5_words", 64'(words_a - w0), 64'd32);

        // 6: FIRST_REG=30 dumps only idx 30 and 31
        q_b.push_back(mk_word(30));
        q_b.push_back(mk_word(31));
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!(dif_b.dout_valid && dif_b.dout_idx == 5'd31) && n < 50) begin tick(); n++; end
        chk("t6_reach_idx31", {63'd0, dif_b.dout_valid}, 64'd1);
        chk("t6_no_done_yet", {63'd0, done_b}, 64'd0);
        tick();
        chk("t6_done", {63'd0, done_b}, 64'd1);
        chk("t6_busy_in_done", {63'd0, busy_b}, 64'd1);
        tick();
        chk("t6_done_pulse", {63'd0, done_b}, 64'd0);
        chk("t6_idle", {63'd0, busy_b}, 64'd0);
        chk("t6_words", 64'(words_b), 64'd2);

        tick();
        chk("end_qa_empty", 64'(q_a.size()), 64'd0);
        chk("end_qb_empty", 64'(q_b.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
